// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register, 1-cycle latency; priority rst > flush_e (bubble) > stall_e (hold) > load.
// Optional saturating flush counter on bubble_cnt when ID_EX_BUBBLE_CNT_EN is defined, else tied to 0.
module id_ex_pipe_reg #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_e,
  input  logic                flush_e,
  input  logic                valid_d,
  input  logic [1:0]          result_src_d,
  input  logic                mem_write_d,
  input  logic                alu_src_d,
  input  logic                reg_write_d,
  input  logic                jump_src_d,
  input  logic                a_type_d,
  input  logic                jump_d,
  input  logic                branch_d,
  input  logic [2:0]          alu_ctrl_d,
  input  logic [2:0]          funct3_d,
  input  logic [WIDTH-1:0]    rd1_d,
  input  logic [WIDTH-1:0]    rd2_d,
  input  logic [WIDTH-1:0]    imm_ext_d,
  input  logic [WIDTH-1:0]    pc_d,
  input  logic [WIDTH-1:0]    pc_plus4_d,
  input  logic [REG_ADDR-1:0] rs1_d,
  input  logic [REG_ADDR-1:0] rs2_d,
  input  logic [REG_ADDR-1:0] rd_d,
  output logic                valid_e,
  output logic [1:0]          result_src_e,
  output logic                mem_write_e,
  output logic                alu_src_e,
  output logic                reg_write_e,
  output logic                jump_src_e,
  output logic                a_type_e,
  output logic                jump_e,
  output logic                branch_e,
  output logic [2:0]          alu_ctrl_e,
  output logic [2:0]          funct3_e,
  output logic [WIDTH-1:0]    rd1_e,
  output logic [WIDTH-1:0]    rd2_e,
  output logic [WIDTH-1:0]    imm_ext_e,
  output logic [WIDTH-1:0]    pc_e,
  output logic [WIDTH-1:0]    pc_plus4_e,
  output logic [REG_ADDR-1:0] rs1_e,
  output logic [REG_ADDR-1:0] rs2_e,
  output logic [REG_ADDR-1:0] rd_e,
  output logic [31:0]         bubble_cnt
);

  typedef struct packed {
    logic       valid;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump_src;
    logic       a_type;
    logic       jump;
    logic       branch;
    logic [2:0] alu_ctrl;
    logic [2:0] funct3;
  } ctrl_t;

  typedef struct packed {
    logic [WIDTH-1:0]    rd1;
    logic [WIDTH-1:0]    rd2;
    logic [WIDTH-1:0]    imm_ext;
    logic [WIDTH-1:0]    pc;
    logic [WIDTH-1:0]    pc_plus4;
    logic [REG_ADDR-1:0] rs1;
    logic [REG_ADDR-1:0] rs2;
    logic [REG_ADDR-1:0] rd;
  } data_t;

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;

  always_comb begin
    ctrl_d.valid      = valid_d;
    ctrl_d.result_src = result_src_d;
    ctrl_d.mem_write  = mem_write_d;
    ctrl_d.alu_src    = alu_src_d;
    ctrl_d.reg_write  = reg_write_d;
    ctrl_d.jump_src   = jump_src_d;
    ctrl_d.a_type     = a_type_d;
    ctrl_d.jump       = jump_d;
    ctrl_d.branch     = branch_d;
    ctrl_d.alu_ctrl   = alu_ctrl_d;
    ctrl_d.funct3     = funct3_d;
    data_d.rd1        = rd1_d;
    data_d.rd2        = rd2_d;
    data_d.imm_ext    = imm_ext_d;
    data_d.pc         = pc_d;
    data_d.pc_plus4   = pc_plus4_d;
    data_d.rs1        = rs1_d;
    data_d.rs2        = rs2_d;
    data_d.rd         = rd_d;
  end

  // Bubbles also zero the data/index fields so rd_e = x0 never matches a forwarding compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (flush_e) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (!stall_e) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign valid_e      = ctrl_q.valid;
  assign result_src_e = ctrl_q.result_src;
  assign mem_write_e  = ctrl_q.mem_write;
  assign alu_src_e    = ctrl_q.alu_src;
  assign reg_write_e  = ctrl_q.reg_write;
  assign jump_src_e   = ctrl_q.jump_src;
  assign a_type_e     = ctrl_q.a_type;
  assign jump_e       = ctrl_q.jump;
  assign branch_e     = ctrl_q.branch;
  assign alu_ctrl_e   = ctrl_q.alu_ctrl;
  assign funct3_e     = ctrl_q.funct3;
  assign rd1_e        = data_q.rd1;
  assign rd2_e        = data_q.rd2;
  assign imm_ext_e    = data_q.imm_ext;
  assign pc_e         = data_q.pc;
  assign pc_plus4_e   = data_q.pc_plus4;
  assign rs1_e        = data_q.rs1;
  assign rs2_e        = data_q.rs2;
  assign rd_e         = data_q.rd;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  // Counts flush edges (stall or not), saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (flush_e && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed vector table, reset/saturation sequences,
// then random stall/flush/reset traffic against a behavioural model.
module tb_id_ex_pipe_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic        jump_src;
    logic        a_type;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_ctrl;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } bundle_t;

  typedef struct {
    logic    stall;
    logic    flush;
    bundle_t din;
    bundle_t exp;
    int      nflush;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_e = 1'b0;
  logic flush_e = 1'b0;
  bundle_t din = '0;
  bundle_t dout;
  logic [31:0] bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.WIDTH(32), .REG_ADDR(5)) dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(din.valid), .result_src_d(din.result_src), .mem_write_d(din.mem_write),
    .alu_src_d(din.alu_src), .reg_write_d(din.reg_write), .jump_src_d(din.jump_src),
    .a_type_d(din.a_type), .jump_d(din.jump), .branch_d(din.branch),
    .alu_ctrl_d(din.alu_ctrl), .funct3_d(din.funct3),
    .rd1_d(din.rd1), .rd2_d(din.rd2), .imm_ext_d(din.imm), .pc_d(din.pc),
    .pc_plus4_d(din.pc4), .rs1_d(din.rs1), .rs2_d(din.rs2), .rd_d(din.rd),
    .valid_e(dout.valid), .result_src_e(dout.result_src), .mem_write_e(dout.mem_write),
    .alu_src_e(dout.alu_src), .reg_write_e(dout.reg_write), .jump_src_e(dout.jump_src),
    .a_type_e(dout.a_type), .jump_e(dout.jump), .branch_e(dout.branch),
    .alu_ctrl_e(dout.alu_ctrl), .funct3_e(dout.funct3),
    .rd1_e(dout.rd1), .rd2_e(dout.rd2), .imm_ext_e(dout.imm), .pc_e(dout.pc),
    .pc_plus4_e(dout.pc4), .rs1_e(dout.rs1), .rs2_e(dout.rs2), .rd_e(dout.rd),
    .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bundle_t rnd_bundle();
    bundle_t b;
    b.valid      = 1'($urandom);
    b.result_src = 2'($urandom);
    b.mem_write  = 1'($urandom);
    b.alu_src    = 1'($urandom);
    b.reg_write  = 1'($urandom);
    b.jump_src   = 1'($urandom);
    b.a_type     = 1'($urandom);
    b.jump       = 1'($urandom);
    b.branch     = 1'($urandom);
    b.alu_ctrl   = 3'($urandom);
    b.funct3     = 3'($urandom);
    b.rd1        = $urandom;
    b.rd2        = $urandom;
    b.imm        = $urandom;
    b.pc         = $urandom;
    b.pc4        = $urandom;
    b.rs1        = 5'($urandom);
    b.rs2        = 5'($urandom);
    b.rd         = 5'($urandom);
    return b;
  endfunction

  function automatic logic [31:0] exp_cnt(input longint n);
    if (!CNT_EN) return 32'h0;
    if (n > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return n[31:0];
  endfunction

  bundle_t a, b, c, zero_b, model;
  longint  model_cnt;
  vec_t    tbl[12];

  initial begin
    zero_b = '0;
    a = '0;
    a.rd1 = 32'hDEAD_BEEF; a.rd = 5'd7; a.reg_write = 1'b1; a.alu_ctrl = 3'b010; a.valid = 1'b1;
    b = rnd_bundle(); b.valid = 1'b1; b.rd = 5'd12;
    c = rnd_bundle(); c.valid = 1'b1; c.mem_write = 1'b1; c.rd = 5'd31;

    // stall, flush, din, expected, cumulative flush count
    tbl[0]  = '{1'b0, 1'b0, a, a, 0};
    tbl[1]  = '{1'b1, 1'b0, b, a, 0};
    tbl[2]  = '{1'b1, 1'b0, b, a, 0};
    tbl[3]  = '{1'b1, 1'b0, b, a, 0};
    tbl[4]  = '{1'b0, 1'b0, b, b, 0};
    tbl[5]  = '{1'b1, 1'b1, c, zero_b, 1};
    tbl[6]  = '{1'b0, 1'b0, c, c, 1};
    tbl[7]  = '{1'b0, 1'b1, a, zero_b, 2};
    tbl[8]  = '{1'b0, 1'b1, a, zero_b, 3};
    tbl[9]  = '{1'b0, 1'b1, a, zero_b, 4};
    tbl[10] = '{1'b0, 1'b1, a, zero_b, 5};
    tbl[11] = '{1'b0, 1'b0, a, a, 5};

    // Reset state before any clock edge
    din = c;
    #1;
    check("reset_outputs", 256'(dout), 256'(zero_b));
    check("reset_cnt", 256'(bubble_cnt), 256'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      stall_e = tbl[i].stall;
      flush_e = tbl[i].flush;
      din     = tbl[i].din;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_outputs", i), 256'(dout), 256'(tbl[i].exp));
      check($sformatf("vec%0d_cnt", i), 256'(bubble_cnt), 256'(exp_cnt(longint'(tbl[i].nflush))));
    end
    stall_e = 1'b0;
    flush_e = 1'b0;

    // Asynchronous reset between edges, then capture on the first edge after release
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", 256'(dout), 256'(zero_b));
    check("async_rst_cnt", 256'(bubble_cnt), 256'h0);
    din = b;
    @(negedge clk);
    check("rst_held_outputs", 256'(dout), 256'(zero_b));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_capture", 256'(dout), 256'(b));
    check("post_rst_cnt", 256'(bubble_cnt), 256'h0);

    // Random traffic against the model
    model = b;
    model_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      bundle_t nd;
      logic r, s, f;
      nd = rnd_bundle();
      r  = ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 6) == 0);
      din = nd; stall_e = s; flush_e = f; rst = r;
      if (r) begin
        model = '0; model_cnt = 0;
      end else if (f) begin
        model = '0; model_cnt++;
      end else if (!s) begin
        model = nd;
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rand%0d_outputs", k), 256'(dout), 256'(model));
      check($sformatf("rand%0d_cnt", k), 256'(bubble_cnt), 256'(exp_cnt(model_cnt)));
      rst = 1'b0;
    end
    stall_e = 1'b0;
    flush_e = 1'b0;

`ifdef ID_EX_BUBBLE_CNT_EN
    // Saturation from a preset near-full counter
    force dut.bubble_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt_q;
    flush_e = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("sat%0d_cnt", k), 256'(bubble_cnt), 256'(32'hFFFF_FFFF));
      check($sformatf("sat%0d_bubble", k), 256'(dout), 256'(zero_b));
    end
    flush_e = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Decode-to-execute pipeline register for the pipelined RV32I core. It captures the control bundle from the decode-stage control unit, plus the register-file operands, immediate, PC and register indices. It presents them to the execute stage one cycle later. It supports hazard-driven stall (hold) and flush (bubble insertion), and carries a valid bit so that downstream stages can tell real instructions from bubbles.

## Interface
Parameters:
- WIDTH, 32, datapath width (operands, immediate, PC)
- REG_ADDR, 5, register index width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall_e  input  1  hold current contents (from hazard unit)
- flush_e  input  1  replace next contents with a bubble (from hazard unit / branch resolution)
- valid_d  input  1  decode stage holds a real instruction
- result_src_d  input  2  write-back mux select
- mem_write_d, alu_src_d, reg_write_d, jump_src_d, a_type_d, jump_d, branch_d  input  1 each  decode control bits
- alu_ctrl_d  input  3  ALU operation
- funct3_d  input  3  branch/load/store sub-type
- rd1_d, rd2_d  input  WIDTH  register-file read data
- imm_ext_d  input  WIDTH  sign-extended immediate
- pc_d, pc_plus4_d  input  WIDTH  instruction PC and PC+4
- rs1_d, rs2_d, rd_d  input  REG_ADDR  register indices (used for forwarding)
- *_e outputs  output  same widths  registered copies of every *_d input above, including valid_e
- bubble_cnt  output  32  bubble counter (see Configuration)

## Operation
- One register stage. Every *_e output is a flop. There is no combinational path from input to output.
- Priority per rising edge, highest first:
  - rst
  - flush_e
  - stall_e
  - load
- Flush:
  - All control outputs go to 0: reg_write_e, mem_write_e, jump_e, branch_e, result_src_e, alu_ctrl_e, alu_src_e, jump_src_e, a_type_e, funct3_e.
  - valid_e goes to 0.
  - Data and index outputs (rd1/rd2/imm/pc/pc_plus4/rs1/rs2/rd) also go to 0. The bubble therefore never matches a forwarding source (rd_e = x0).
- Stall without flush: all outputs hold their previous values, valid_e included.
- Load (neither asserted): every *_e output takes its *_d value.
- A bubble is fully defined by its zero controls: reg_write_e = 0 and mem_write_e = 0 guarantee it has no architectural effect.
- Flush and stall in the same cycle: flush wins and a bubble is inserted. This is required when a taken branch coincides with a load-use stall.
- The block never decodes instructions. Fields pass through bit-exact.

## Timing
- Latency: exactly 1 cycle from *_d sampled at edge N to *_e valid after edge N.
- Reset is asynchronous: all outputs go to 0 immediately on rst rising, independent of clk. This includes valid_e = 0 and bubble_cnt = 0.
- Reset release is observed at the next rising clk edge. The first capture happens at the first edge with rst low.
- Reset asserted mid-stall or mid-flush: reset dominates. Pending stall/flush state is not retained (the block holds no hidden state apart from the counter).
- Back-to-back flushes produce consecutive bubbles, one per cycle.
- A stall held for K cycles keeps the outputs constant for K cycles. The instruction presented on *_d at the first non-stall edge is captured.

## Configuration
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - bubble_cnt is a 32-bit counter, reset to 0.
  - It increments by 1 on every rising edge where flush_e = 1 and rst = 0. This count includes flush-with-stall edges.
  - It saturates at 32'hFFFF_FFFF; it does not wrap.
- Not defined: bubble_cnt is tied to 32'h0 and no counter flops are synthesized. The port list is identical in both builds.

## Test plan
- Reset mid-operation: load nonzero values, assert rst between clock edges.
  - All *_e outputs and bubble_cnt drop to 0 without a clock edge.
  - After release, the first edge captures *_d.
- Plain load: drive rd1_d = 32'hDEAD_BEEF, rd_d = 5'd7, reg_write_d = 1, alu_ctrl_d = 3'b010, valid_d = 1.
  - The next edge gives identical *_e values and valid_e = 1.
- Stall: load instruction A, then hold stall_e = 1 for 3 cycles while *_d changes to B.
  - Outputs stay at A for 3 cycles.
  - B appears one edge after stall_e drops.
- Flush priority: with instruction A loaded, assert flush_e = 1 and stall_e = 1 together.
  - The next edge gives a bubble: reg_write_e = 0, mem_write_e = 0, rd_e = 0, valid_e = 0.
  - bubble_cnt = 1 (with ID_EX_BUBBLE_CNT_EN).
- Consecutive flushes: flush_e = 1 for 4 cycles.
  - 4 bubbles are produced and bubble_cnt = 4.
  - Without the macro, bubble_cnt stays 0.
- Saturation (ID_EX_BUBBLE_CNT_EN, counter forced to 32'hFFFF_FFFE): apply 3 flush edges.
  - bubble_cnt = 32'hFFFF_FFFF and holds there.
